// File: rtl/mem_defines.sv
// Shared memory-access types for the TCM port: access sizes, RAM geometry and response record.
package mem_defines;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    localparam int TCM_ADDR_W = 14;
    localparam int TCM_DATA_W = 32;

    typedef struct packed {
        logic [TCM_DATA_W-1:0] rdata;
        logic                  err;
    } tcm_resp_t;

    // Request attributes carried from the address cycle to the data cycle.
    typedef struct packed {
        logic      we;
        mem_size_t size;
        logic      uns;
        logic [1:0] lane;
        logic      err;
    } tcm_pend_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return lane[0];
            default: return lane != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/tcm_resp_fifo.sv
// Shift-register response FIFO: entry 0 is always the head, so the head is a plain register
// and stays stable while the consumer stalls.
module tcm_resp_fifo
    import mem_defines::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  tcm_resp_t     push_data_i,
    input  logic          pop_i,
    output tcm_resp_t     head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    tcm_resp_t     ent_q [DEPTH];
    tcm_resp_t     ent_d [DEPTH];
    logic [CW-1:0] count_q, count_d, cnt_pop;
    logic          pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = ent_q[0];

    always_comb begin
        ent_d   = ent_q;
        pop_en  = pop_i && !empty_o;
        cnt_pop = count_q - CW'(pop_en);
        if (pop_en) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
            ent_d[DEPTH-1] = '0;
        end
        // New entry lands right behind whatever survives this cycle's pop.
        if (push_i) begin
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == cnt_pop) ent_d[i] = push_data_i;
        end
        count_d = cnt_pop + CW'(push_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

endmodule

// File: rtl/tcm_port_master.sv
// Load/store initiator for one TCM RAM port with in-order, credit-limited responses.
// Optional misalignment trapping is enabled by defining TCM_PORT_ALIGN_CHECK_EN.
module tcm_port_master
    import mem_defines::*;
#(
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [15:0]           req_addr_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_err_o,
    output logic [TCM_ADDR_W-1:0] addr_o,
    output logic [TCM_DATA_W-1:0] data_o,
    output logic [3:0]            wr_o,
    input  logic [TCM_DATA_W-1:0] data_i
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int OW = CW + 1;

    logic          req_fire, misalign, resp_pop;
    logic [3:0]    strb;
    logic          pend_vld_q, pend_vld_d;
    tcm_pend_t     pend_q, pend_d;
    tcm_resp_t     push_data, head;
    logic          fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] occ;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ext;

    // Credit counts queued plus in-flight responses, crediting back a pop in the same cycle.
    assign resp_valid_o = !fifo_empty;
    assign resp_pop     = resp_valid_o && resp_ready_i;
    assign occ          = OW'(fifo_count) - OW'(resp_pop) + OW'(pend_vld_q);
    assign req_ready_o  = rst_i && (occ < OW'(RESP_DEPTH));
    assign req_fire     = req_valid_i && req_ready_o;

`ifdef TCM_PORT_ALIGN_CHECK_EN
    assign misalign = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign addr_o = req_addr_i[15:2];

    always_comb begin
        data_o = req_wdata_i;
        strb   = 4'hF;
        case (mem_size_t'(req_size_i))
            MEM_B: begin
                data_o = {4{req_wdata_i[7:0]}};
                strb   = 4'b0001 << req_addr_i[1:0];
            end
            MEM_H: begin
                data_o = {2{req_wdata_i[15:0]}};
                strb   = 4'b0011 << {req_addr_i[1], 1'b0};
            end
            default: ;
        endcase
        wr_o = (req_fire && req_we_i && !misalign) ? strb : 4'h0;
    end

    always_comb begin
        pend_vld_d = req_fire;
        pend_d     = pend_q;
        if (req_fire) begin
            pend_d.we   = req_we_i;
            pend_d.size = mem_size_t'(req_size_i);
            pend_d.uns  = req_unsigned_i;
            pend_d.lane = req_addr_i[1:0];
            pend_d.err  = misalign;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        case (pend_q.lane)
            2'd0:    bsel = data_i[7:0];
            2'd1:    bsel = data_i[15:8];
            2'd2:    bsel = data_i[23:16];
            default: bsel = data_i[31:24];
        endcase
        hsel = pend_q.lane[1] ? data_i[31:16] : data_i[15:0];
        case (pend_q.size)
            MEM_B:   ext = {{24{!pend_q.uns && bsel[7]}}, bsel};
            MEM_H:   ext = {{16{!pend_q.uns && hsel[15]}}, hsel};
            default: ext = data_i;
        endcase
        push_data.rdata = (pend_q.we || pend_q.err) ? '0 : ext;
        push_data.err   = pend_q.err;
    end

    // Credit already rules out overflow; the guard only keeps a full FIFO from being corrupted.
    assign fifo_push = pend_vld_q && (!fifo_full || resp_pop);

    tcm_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .CW    (CW)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (push_data),
        .pop_i       (resp_pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign resp_rdata_o = head.rdata;
    assign resp_err_o   = head.err;

endmodule

// File: tb/tb_tcm_port_master.sv
// Bench for tcm_port_master: byte-level memory model with an in-order expected-response queue.
module tb_tcm_port_master;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [15:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o, resp_ready_i = 1'b0, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic [13:0] addr_o;
    logic [31:0] data_o, data_i;
    logic [3:0]  wr_o;

    always #5 clk = ~clk;

    tcm_port_master #(.RESP_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .addr_o(addr_o), .data_o(data_o), .wr_o(wr_o), .data_i(data_i)
    );

    // RAM attached to the port: byte-strobed writes, one-cycle registered read.
    logic [31:0] ram [0:16383];
    logic [31:0] rd_q = '0;
    always @(posedge clk) begin
        rd_q <= ram[addr_o];
        for (int k = 0; k < 4; k++)
            if (wr_o[k]) ram[addr_o][8*k +: 8] <= data_o[8*k +: 8];
    end
    assign data_i = rd_q;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic [7:0]  mb [0:255];
    exp_t        q[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          fires = 0, pops = 0, last_lat = 0;
    logic [31:0] last_rdata = '0, prev_rdata = '0;
    logic        last_err = 1'b0, prev_err = 1'b0, prev_stall = 1'b0;
    logic [3:0]  last_wr = '0;
    logic [13:0] last_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            prev_stall = 1'b0;
        end else begin
            logic exp_v;
            exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("resp_valid", resp_valid_o, exp_v);
            if (prev_stall) begin
                chk("stall_rdata", resp_rdata_o, prev_rdata);
                chk("stall_err", resp_err_o, prev_err);
            end
            prev_stall = resp_valid_o && !resp_ready_i;
            prev_rdata = resp_rdata_o;
            prev_err   = resp_err_o;
            if (resp_valid_o && resp_ready_i) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected actual=valid required=none");
                end else begin
                    chk("resp_rdata", resp_rdata_o, q[0].rdata);
                    chk("resp_err", resp_err_o, q[0].err);
                    last_lat   = cyc - q[0].acc;
                    last_rdata = resp_rdata_o;
                    last_err   = resp_err_o;
                    void'(q.pop_front());
                    pops++;
                end
            end
            chk("req_ready", req_ready_o, q.size() < DEPTH);
            if (req_valid_i && req_ready_o) begin
                exp_t        e;
                int          a, nb, base;
                logic        mis;
                logic [3:0]  ewr;
                logic [31:0] v;
                a    = int'(req_addr_i);
                nb   = (req_size_i == 2'd0) ? 1 : (req_size_i == 2'd1) ? 2 : 4;
                base = a & ~(nb - 1);
`ifdef TCM_PORT_ALIGN_CHECK_EN
                mis = (a % nb) != 0;
`else
                mis = 1'b0;
`endif
                ewr = '0;
                v   = '0;
                chk("addr_o", addr_o, a >> 2);
                if (!mis) begin
                    if (req_we_i) begin
                        for (int k = 0; k < nb; k++) begin
                            mb[base+k] = req_wdata_i[8*k +: 8];
                            ewr[(base & 3) + k] = 1'b1;
                            chk("data_o_lane", data_o[8*((base & 3) + k) +: 8], req_wdata_i[8*k +: 8]);
                        end
                    end else begin
                        for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[base+k];
                        if (!req_unsigned_i && v[8*nb-1])
                            for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
                    end
                end
                chk("wr_o", wr_o, ewr);
                e.rdata = v;
                e.err   = mis;
                e.acc   = cyc;
                q.push_back(e);
                fires++;
                last_wr   = wr_o;
                last_addr = addr_o;
            end else begin
                chk("wr_idle", wr_o, 4'h0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic un,
                        input logic [15:0] a, input logic [31:0] wd);
        int n;
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
        req_unsigned_i = un; req_addr_i = a; req_wdata_i = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            errors++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    initial begin
        int t0, f0, p0;
        for (int i = 0; i < 16384; i++) ram[i] = (i < 64) ? $urandom : 32'h0;
        for (int i = 0; i < 256; i++) mb[i] = ram[i/4][8*(i%4) +: 8];

        // Reset state, including a store presented while in reset.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_addr_i = 16'h0004;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1'b0);
        chk("rst_resp_valid", resp_valid_o, 1'b0);
        chk("rst_rdata", resp_rdata_o, 32'h0);
        chk("rst_err", resp_err_o, 1'b0);
        chk("rst_wr", wr_o, 4'h0);
        @(posedge clk);
        #1 req_valid_i = 1'b0; rst_i = 1'b1; resp_ready_i = 1'b1;

        // Word store then load.
        send(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        chk("t1_wr", last_wr, 4'hF);
        chk("t1_addr", last_addr, 14'h004);
        send(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        idle(4);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);
        chk("t1_latency", last_lat, 2);

        // Byte store, signed and unsigned loads.
        send(1'b1, 2'd0, 1'b0, 16'h0013, 32'h00000080);
        chk("t2_wr", last_wr, 4'b1000);
        send(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0);
        idle(4);
        chk("t2_signed", last_rdata, 32'hFFFFFF80);
        send(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
        idle(4);
        chk("t2_unsigned", last_rdata, 32'h00000080);

        // Eight back-to-back loads, one per cycle.
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(1'b0, 2'd2, 1'b0, 16'(4 * i), 32'h0);
        chk("t3_cycles", cyc - t0, 8);
        idle(5);
        chk("t3_drained", q.size(), 0);

        // Stalled consumer: credit limit then in-order drain.
        resp_ready_i = 1'b0;
        f0 = fires;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd1; req_unsigned_i = 1'b0;
        req_addr_i = 16'h0022;
        idle(6);
        chk("t4_accepted", fires - f0, DEPTH);
        chk("t4_ready_low", req_ready_o, 1'b0);
        req_valid_i = 1'b0;
        p0 = pops;
        resp_ready_i = 1'b1;
        idle(6);
        chk("t4_drain", pops - p0, DEPTH);

        // Half store at an odd address.
        send(1'b1, 2'd1, 1'b0, 16'h0021, 32'h00001234);
        idle(4);
`ifdef TCM_PORT_ALIGN_CHECK_EN
        chk("t5_wr", last_wr, 4'h0);
        chk("t5_err", last_err, 1'b1);
`else
        chk("t5_wr", last_wr, 4'b0011);
        chk("t5_err", last_err, 1'b0);
`endif

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            req_valid_i    = ($urandom_range(0, 9) < 7);
            req_we_i       = $urandom_range(0, 1);
            req_size_i     = 2'($urandom_range(0, 2));
            req_unsigned_i = $urandom_range(0, 1);
            req_addr_i     = 16'($urandom_range(0, 255));
            req_wdata_i    = $urandom;
            resp_ready_i   = ($urandom_range(0, 9) < 7);
            idle(1);
        end
        req_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        idle(6);
        chk("rand_drained", q.size(), 0);

        // Reset with two responses queued.
        resp_ready_i = 1'b0;
        send(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0);
        send(1'b0, 2'd2, 1'b0, 16'h0004, 32'h0);
        idle(3);
        rst_i = 1'b0;
        q.delete();
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2;
        #1;
        chk("t6_valid_drop", resp_valid_o, 1'b0);
        chk("t6_ready_rst", req_ready_o, 1'b0);
        chk("t6_wr_rst", wr_o, 4'h0);
        idle(2);
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("t6_ready_after", req_ready_o, 1'b1);
        chk("t6_empty_after", resp_valid_o, 1'b0);
        resp_ready_i = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
